// File: rtl/sci_slave.sv
// SCI responder: turns serial SCI frames into single-cycle register-file accesses.
// Build option SCI_SLAVE_PARITY_EN adds even parity on write frames, read addresses and read data.
//
// state | meaning
// IDLE  | deselected or waiting for the first frame bit (WNR)
// ADDR  | shifting in address bits (plus address parity on parity reads)
// WDATA | shifting in write data (plus frame parity on parity writes)
// WRITE | register write strobe and completion ack
// READ  | register read strobe
// RCAP  | capture read data into the shift register
// RESP  | shifting read data out on SCI_RESP, ack on the last bit
// DONE  | frame finished, waiting for chip select to drop
module sci_slave #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  SCI_CSN,
    input  logic                  SCI_REQ,
    inout  wire                   SCI_RESP,
    inout  wire                   SCI_ACK,
    output logic [ADDR_WIDTH-1:0] REG_ADDR,
    output logic                  REG_WE,
    output logic [DATA_WIDTH-1:0] REG_WDATA,
    output logic                  REG_RE,
    input  logic [DATA_WIDTH-1:0] REG_RDATA
);

    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = (MAX_W < 1) ? 1 : $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_WIDTH - 1);
`ifdef SCI_SLAVE_PARITY_EN
    localparam logic [CNT_W-1:0] A_LAST_P = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] D_LAST_P = CNT_W'(DATA_WIDTH);
`endif

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        READ,
        RCAP,
        RESP,
        DONE
    } state_t;

    state_t                  state;
    state_t                  nxt_state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_load;
    logic                    tc;
    logic                    wnr;
    logic [ADDR_WIDTH-1:0]   addr_sr;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [DATA_WIDTH-1:0]   data_sr;
    logic [DATA_WIDTH-1:0]   data_next;
    logic                    resp_d;
    logic                    ack_d;
`ifdef SCI_SLAVE_PARITY_EN
    logic                    par_acc;
    logic                    par_err;
    logic                    par_bad;
    logic                    rpar;
`endif

    assign tc        = (cnt == '0);
    assign addr_next = (addr_sr << 1) | ADDR_WIDTH'(SCI_REQ);
    assign data_next = (data_sr << 1) | DATA_WIDTH'(SCI_REQ);
`ifdef SCI_SLAVE_PARITY_EN
    assign par_bad   = par_acc ^ SCI_REQ;
`endif

    // Shared bus lines: only driven while this neuron is selected.
    assign SCI_RESP = SCI_CSN ? 1'bz : resp_d;
    assign SCI_ACK  = SCI_CSN ? 1'bz : ack_d;

    always_comb begin
        nxt_state = state;
        cnt_load  = '0;
        REG_WE    = 1'b0;
        REG_RE    = 1'b0;
        resp_d    = 1'b0;
        ack_d     = 1'b0;
        case (state)
            IDLE: begin
                if (!SCI_CSN) begin
                    nxt_state = ADDR;
`ifdef SCI_SLAVE_PARITY_EN
                    cnt_load  = SCI_REQ ? A_LAST : A_LAST_P;
`else
                    cnt_load  = A_LAST;
`endif
                end
            end
            ADDR: begin
                if (tc) begin
                    nxt_state = wnr ? WDATA : READ;
`ifdef SCI_SLAVE_PARITY_EN
                    cnt_load  = wnr ? D_LAST_P : '0;
`else
                    cnt_load  = wnr ? D_LAST : '0;
`endif
                end
            end
            WDATA: begin
                if (tc) begin
                    nxt_state = WRITE;
                end
            end
            WRITE: begin
                ack_d     = 1'b1;
`ifdef SCI_SLAVE_PARITY_EN
                REG_WE    = !par_err;
                resp_d    = par_err;
`else
                REG_WE    = 1'b1;
`endif
                nxt_state = DONE;
            end
            READ: begin
`ifdef SCI_SLAVE_PARITY_EN
                REG_RE    = !par_err;
`else
                REG_RE    = 1'b1;
`endif
                nxt_state = RCAP;
            end
            RCAP: begin
                nxt_state = RESP;
`ifdef SCI_SLAVE_PARITY_EN
                cnt_load  = D_LAST_P;
`else
                cnt_load  = D_LAST;
`endif
            end
            RESP: begin
`ifdef SCI_SLAVE_PARITY_EN
                resp_d = tc ? rpar : data_sr[DATA_WIDTH-1];
`else
                resp_d = data_sr[DATA_WIDTH-1];
`endif
                ack_d  = tc;
                if (tc) begin
                    nxt_state = DONE;
                end
            end
            DONE: begin
                if (SCI_CSN) begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
        // Deselect mid-frame abandons the access without a strobe or ack.
        if (SCI_CSN && (state != IDLE) && (state != DONE)) begin
            nxt_state = IDLE;
            cnt_load  = '0;
            REG_WE    = 1'b0;
            REG_RE    = 1'b0;
            resp_d    = 1'b0;
            ack_d     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            cnt       <= '0;
            wnr       <= 1'b0;
            addr_sr   <= '0;
            data_sr   <= '0;
            REG_ADDR  <= '0;
            REG_WDATA <= '0;
`ifdef SCI_SLAVE_PARITY_EN
            par_acc   <= 1'b0;
            par_err   <= 1'b0;
            rpar      <= 1'b0;
`endif
        end else begin
            state <= nxt_state;
            if (nxt_state != state) begin
                cnt <= cnt_load;
            end else if (!tc) begin
                cnt <= cnt - CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (!SCI_CSN) begin
                        wnr <= SCI_REQ;
`ifdef SCI_SLAVE_PARITY_EN
                        par_acc <= SCI_REQ;
                        par_err <= 1'b0;
`endif
                    end
                end
                ADDR: begin
`ifdef SCI_SLAVE_PARITY_EN
                    par_acc <= par_bad;
                    if (!(tc && !wnr)) begin
                        addr_sr <= addr_next;
                    end
                    if (nxt_state == READ) begin
                        par_err <= par_bad;
                        if (!par_bad) begin
                            REG_ADDR <= addr_sr;
                        end
                    end
`else
                    addr_sr <= addr_next;
                    if (nxt_state == READ) begin
                        REG_ADDR <= addr_next;
                    end
`endif
                end
                WDATA: begin
`ifdef SCI_SLAVE_PARITY_EN
                    par_acc <= par_bad;
                    if (!tc) begin
                        data_sr <= data_next;
                    end
                    if (nxt_state == WRITE) begin
                        par_err <= par_bad;
                        if (!par_bad) begin
                            REG_ADDR  <= addr_sr;
                            REG_WDATA <= data_sr;
                        end
                    end
`else
                    data_sr <= data_next;
                    if (nxt_state == WRITE) begin
                        REG_ADDR  <= addr_sr;
                        REG_WDATA <= data_next;
                    end
`endif
                end
                RCAP: begin
`ifdef SCI_SLAVE_PARITY_EN
                    // A rejected address answers with zero data and a deliberately wrong parity bit.
                    data_sr <= par_err ? '0 : REG_RDATA;
                    rpar    <= par_err ? 1'b1 : ^REG_RDATA;
`else
                    data_sr <= REG_RDATA;
`endif
                end
                RESP: begin
                    data_sr <= data_sr << 1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sci_slave.sv
// Bench for sci_slave: directed SCI frames plus random traffic checked against a frame-level model.
module tb_sci_slave;
    localparam int A = 5;
    localparam int D = 32;
`ifdef SCI_SLAVE_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sci_csn = 1'b1;
    logic         sci_req = 1'b0;
    wire          sci_resp;
    wire          sci_ack;
    logic [A-1:0] reg_addr;
    logic         reg_we;
    logic [D-1:0] reg_wdata;
    logic         reg_re;
    logic [D-1:0] reg_rdata;

    logic [D-1:0] mem     [0:31];
    logic [D-1:0] ref_mem [0:31];
    int vectors = 0;
    int miscompares = 0;
    int we_seen = 0;
    int we_expected = 0;

    // Released bus lines read as 1, so a driven 0 and high-Z are distinguishable.
    pullup (sci_resp);
    pullup (sci_ack);

    always #5 clk = ~clk;

    sci_slave #(.ADDR_WIDTH(A), .DATA_WIDTH(D)) dut (
        .CLK       (clk),
        .RSTN      (rst_n),
        .SCI_CSN   (sci_csn),
        .SCI_REQ   (sci_req),
        .SCI_RESP  (sci_resp),
        .SCI_ACK   (sci_ack),
        .REG_ADDR  (reg_addr),
        .REG_WE    (reg_we),
        .REG_WDATA (reg_wdata),
        .REG_RE    (reg_re),
        .REG_RDATA (reg_rdata)
    );

    // Neuron register file: read data only valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (reg_we) begin
            mem[reg_addr] <= reg_wdata;
            we_seen <= we_seen + 1;
        end
        reg_rdata <= reg_re ? mem[reg_addr] : D'($urandom);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic csn, input logic req);
        @(posedge clk);
        #1;
        sci_csn = csn;
        sci_req = req;
        @(negedge clk);
    endtask

    task automatic chk_released(input string tag);
        chk({tag, "_resp_z"}, 64'(sci_resp), 64'(1));
        chk({tag, "_ack_z"},  64'(sci_ack),  64'(1));
        chk({tag, "_we"},     64'(reg_we),   64'(0));
    endtask

    task automatic hold_and_release(input int hold);
        for (int k = 0; k < hold; k++) begin
            step(1'b0, 1'($urandom));
            chk("done_we",   64'(reg_we),   64'(0));
            chk("done_re",   64'(reg_re),   64'(0));
            chk("done_ack",  64'(sci_ack),  64'(0));
            chk("done_resp", 64'(sci_resp), 64'(0));
        end
        step(1'b1, 1'b0);
        chk_released("release");
    endtask

    task automatic do_write(input logic [A-1:0] addr, input logic [D-1:0] data,
                            input int abort_at, input bit bad_par, input int hold);
        logic [A+D:0] frame;
        logic b;
        int wcyc;
        frame = {1'b1, addr, data};
        wcyc  = A + D + 1 + PAR;
        for (int c = 0; c <= wcyc; c++) begin
            if (c == abort_at) begin
                step(1'b1, 1'b0);
                chk_released("abort");
                step(1'b1, 1'b0);
                chk_released("abort_idle");
                return;
            end
            if (c <= A + D) b = frame[A+D-c];
            else if (PAR == 1 && c == A + D + 1) b = (^frame) ^ bad_par;
            else b = 1'($urandom);
            step(1'b0, b);
            chk("wr_we",   64'(reg_we),   64'((c == wcyc) && !bad_par));
            chk("wr_ack",  64'(sci_ack),  64'(c == wcyc));
            chk("wr_resp", 64'(sci_resp), 64'((c == wcyc) && bad_par));
            chk("wr_re",   64'(reg_re),   64'(0));
            if (c == wcyc && !bad_par) begin
                chk("wr_addr",  64'(reg_addr),  64'(addr));
                chk("wr_wdata", 64'(reg_wdata), 64'(data));
            end
        end
        if (!bad_par) begin
            ref_mem[addr] = data;
            we_expected++;
        end
        hold_and_release(hold);
    endtask

    task automatic do_read(input logic [A-1:0] addr, input bit bad_par, input int rst_at, input int hold);
        logic [D-1:0] exp_data;
        logic b;
        logic er;
        int rcyc;
        int rs;
        int acyc;
        exp_data = bad_par ? '0 : ref_mem[addr];
        rcyc = A + 1 + PAR;
        rs   = A + 3 + PAR;
        acyc = rs + D - 1 + PAR;
        for (int c = 0; c <= acyc; c++) begin
            if (c == 0) b = 1'b0;
            else if (c <= A) b = addr[A-c];
            else if (PAR == 1 && c == A + 1) b = (^addr) ^ bad_par;
            else b = 1'($urandom);
            step(1'b0, b);
            if (c >= rs && c < rs + D) er = exp_data[D-1-(c-rs)];
            else if (PAR == 1 && c == rs + D) er = (^exp_data) ^ bad_par;
            else er = 1'b0;
            chk("rd_re",   64'(reg_re),   64'((c == rcyc) && !bad_par));
            chk("rd_we",   64'(reg_we),   64'(0));
            chk("rd_resp", 64'(sci_resp), 64'(er));
            chk("rd_ack",  64'(sci_ack),  64'(c == acyc));
            if (c == rcyc && !bad_par) chk("rd_addr", 64'(reg_addr), 64'(addr));
            if (c == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst_we",    64'(reg_we),    64'(0));
                chk("rst_re",    64'(reg_re),    64'(0));
                chk("rst_addr",  64'(reg_addr),  64'(0));
                chk("rst_wdata", 64'(reg_wdata), 64'(0));
                chk("rst_resp",  64'(sci_resp),  64'(0));
                chk("rst_ack",   64'(sci_ack),   64'(0));
                sci_csn = 1'b1;
                rst_n   = 1'b1;
                step(1'b1, 1'b0);
                chk_released("post_rst");
                return;
            end
        end
        hold_and_release(hold);
    endtask

    initial begin
        logic [A-1:0] ra;
        logic [D-1:0] rd;
        int abort_at;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = D'($urandom);
            ref_mem[i] = mem[i];
        end

        #3;
        chk("reset_we",    64'(reg_we),    64'(0));
        chk("reset_re",    64'(reg_re),    64'(0));
        chk("reset_addr",  64'(reg_addr),  64'(0));
        chk("reset_wdata", 64'(reg_wdata), 64'(0));
        chk("reset_resp_z", 64'(sci_resp), 64'(1));
        chk("reset_ack_z",  64'(sci_ack),  64'(1));
        sci_csn = 1'b0;
        #1;
        chk("reset_resp_drv", 64'(sci_resp), 64'(0));
        chk("reset_ack_drv",  64'(sci_ack),  64'(0));
        sci_csn = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        chk_released("idle");

        do_write(5'h05, 32'hDEADBEEF, -1, 1'b0, 1);
        do_read(5'h05, 1'b0, -1, 1);

        mem[3]     = 32'h12345678;
        ref_mem[3] = 32'h12345678;
        do_read(5'h03, 1'b0, -1, 1);

        do_write(5'h02, D'($urandom), 20, 1'b0, 1);
        do_write(5'h01, D'($urandom), -1, 1'b0, 1);
        do_read(5'h02, 1'b0, -1, 1);
        do_read(5'h01, 1'b0, -1, 1);

        do_write(5'h07, 32'h80000000 | D'($urandom), -1, 1'b0, 1);
        do_read(5'h07, 1'b0, A + 3 + PAR, 1);

        do_write(5'h0A, D'($urandom), -1, 1'b0, 6);
        do_read(5'h1F, 1'b0, -1, 1);

`ifdef SCI_SLAVE_PARITY_EN
        do_write(5'h05, 32'hDEADBEEF, -1, 1'b0, 1);
        do_write(5'h05, 32'h0BADF00D, -1, 1'b1, 1);
        do_read(5'h05, 1'b0, -1, 1);
        do_read(5'h05, 1'b1, -1, 1);
`endif

        for (int n = 0; n < 16; n++) begin
            ra = A'($urandom);
            rd = D'($urandom);
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, A + D)) : -1;
            if ($urandom_range(0, 1) == 1) do_write(ra, rd, abort_at, 1'b0, int'($urandom_range(1, 3)));
            else do_read(ra, 1'b0, -1, int'($urandom_range(1, 3)));
        end

        step(1'b1, 1'b0);
        chk("we_count", 64'(we_seen), 64'(we_expected));
        for (int i = 0; i < 32; i++) begin
            chk("regfile", 64'(mem[i]), 64'(ref_mem[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
